pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The block SHALL have parameter AddrSz, default 6, meaning the address width in bits.
REQ-002 The block SHALL have parameter Depth, default 4, meaning the number of return-stack entries (Depth >= 2).
REQ-003 The block SHALL have parameter DW = $clog2(Depth+1), derived, meaning the width of the depth count.
REQ-004 clk  input  1  is the single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-006 stall  input  1  SHALL hold all state for that cycle when high.
REQ-007 op  input  3  is the operation: 000 INC, 001 BRANCH_REL, 010 JUMP_ABS, 011 CALL, 100 RET; 101-111 are reserved.
REQ-008 cond  input  1  is the taken qualifier, used by BRANCH_REL only.
REQ-009 offset  input  AddrSz  is the signed two's-complement relative offset.
REQ-010 target  input  AddrSz  is the absolute target for JUMP_ABS and CALL.
REQ-011 addr  output  AddrSz  is the current program counter, registered.
REQ-012 depth  output  DW  is the number of valid stack entries, registered.
REQ-013 stack_full / stack_empty  output  1 each  SHALL be combinational decodes: depth==Depth and depth==0.
REQ-014 err_ovf / err_unf  output  1 each  are sticky overflow and underflow flags, registered.

Function
REQ-015 All addr arithmetic SHALL be modulo 2^AddrSz, with silent wrap-around and no error flag.
REQ-016 addr, depth and the error flags SHALL change only on a clock edge; the next value takes effect one cycle after op is sampled.
REQ-017 When stall=1, op, cond, offset and target SHALL be ignored, and addr, depth, the stack contents and the error flags SHALL hold.
REQ-018 INC, and any reserved op, SHALL set addr to addr+1.
REQ-019 BRANCH_REL with cond=1 SHALL set addr to addr+offset; with cond=0 it SHALL set addr to addr+1.
REQ-020 JUMP_ABS SHALL set addr to target, independent of cond.
REQ-021 CALL with depth<Depth SHALL write addr+1 to stack entry [depth], set addr to target, and increment depth.
REQ-022 CALL with depth==Depth SHALL leave addr, depth and the stack unchanged and set err_ovf=1.
REQ-023 RET with depth>0 SHALL set addr to stack entry [depth-1] and decrement depth.
REQ-024 RET with depth==0 SHALL leave addr and depth unchanged and set err_unf=1.
REQ-025 The stack SHALL be strictly LIFO; entries at or above depth are don't-care and SHALL NOT be observable.
REQ-026 A CALL whose return address wraps (addr = 2^AddrSz-1) SHALL push 0.
REQ-027 err_ovf and err_unf SHALL stay set once set, with no effect on subsequent operation; only reset SHALL clear them.
REQ-028 The priority order SHALL be: reset > stall > op.
REQ-029 Exactly one op SHALL be executed per non-stalled cycle.
REQ-030 No combinational path SHALL exist from any input to addr, depth or the error flags.

Reset
REQ-031 reset=1 at a clock edge SHALL force addr=0, depth=0, err_ovf=0 and err_unf=0, regardless of stall or op.
REQ-032 Stack contents SHALL NOT need to be cleared on reset.
REQ-033 Reset asserted mid-sequence, for example with calls outstanding, SHALL discard all return addresses.
REQ-034 The first op SHALL be accepted on the first edge with reset=0.
REQ-035 Outputs SHALL be defined from the first reset edge onward.

Verification (AddrSz=6, Depth=4)
REQ-036 Reset, then INC x3 -> addr SHALL go 0,1,2,3, with depth=0, stack_empty=1 and both error flags 0.
REQ-037 Wrap and relative branch: from addr=62, INC,INC -> 63,0; BRANCH_REL offset=6'h3D (-3) cond=1 at addr=1 -> 62; same op with cond=0 -> 63.
REQ-038 Call and return: JUMP_ABS 5; CALL target=20 -> addr=20, depth=1; RET -> addr=6, depth=0; CALL at addr=63 then RET -> addr=0.
REQ-039 Overflow and underflow: CALLs to 10,20,30,40 from 1,10,20,30 -> depth=4, stack_full=1. A 5th CALL -> addr=40 held, err_ovf=1. RET x4 -> addr 31,21,11,2. A 5th RET -> addr=2 held, err_unf=1, err_ovf still 1.
REQ-040 Stall and reset: stall=1 with op=JUMP_ABS target=40 -> addr, depth and flags unchanged. reset=1 together with stall=1, depth=2 and err_ovf=1 -> next cycle addr=0, depth=0, both flags 0.

Source files
------------

// File: rtl/pc_stack_if.sv
// ============================================================================
// Module   : pc_stack_if
// Brief    : Operation inputs and program-counter status outputs of pc_stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_stack_if #(
   parameter int AddrSz = 6,
   parameter int Depth  = 4,
   parameter int DW     = $clog2(Depth + 1)
);
   logic              stall;
   logic [2:0]        op;
   logic              cond;
   logic [AddrSz-1:0] offset;
   logic [AddrSz-1:0] target;
   logic [AddrSz-1:0] addr;
   logic [DW-1:0]     depth;
   logic              stack_full;
   logic              stack_empty;
   logic              err_ovf;
   logic              err_unf;

   modport master (
      output stall, op, cond, offset, target,
      input  addr, depth, stack_full, stack_empty, err_ovf, err_unf
   );

   modport slave (
      input  stall, op, cond, offset, target,
      output addr, depth, stack_full, stack_empty, err_ovf, err_unf
   );
endinterface

`default_nettype wire

// File: rtl/pc_stack.sv
// ============================================================================
// Module   : pc_stack
// Brief    : Program counter with relative/absolute jumps and a LIFO return stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_stack #(
   parameter int AddrSz = 6,
   parameter int Depth  = 4,
   parameter int DW     = $clog2(Depth + 1)
) (
   input  wire logic  clk,
   input  wire logic  reset,
   pc_stack_if.slave  bus
);
   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   localparam logic [2:0] OP_INC    = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   localparam logic [AddrSz-1:0] ADDR_ONE   = AddrSz'(1);
   localparam logic [DW-1:0]     DEPTH_ONE  = DW'(1);
   localparam logic [DW-1:0]     DEPTH_MAX  = DW'(Depth);
   localparam logic [DW-1:0]     DEPTH_ZERO = '0;

   logic [AddrSz-1:0] addr_q, addr_d;
   logic [DW-1:0]     depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [AddrSz-1:0] stack_q [Depth];

   logic              push_en;
   logic [AW-1:0]     push_idx;
   logic [AW-1:0]     pop_idx;
   logic [AddrSz-1:0] addr_inc;
   logic              full;
   logic              empty;

   assign addr_inc = addr_q + ADDR_ONE;
   assign full     = (depth_q == DEPTH_MAX);
   assign empty    = (depth_q == DEPTH_ZERO);
   assign push_idx = depth_q[AW-1:0];
   assign pop_idx  = AW'(depth_q - DEPTH_ONE);

   always_comb begin
      addr_d  = addr_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (!bus.stall) begin
         unique case (bus.op)
            OP_BRANCH: addr_d = bus.cond ? (addr_q + bus.offset) : addr_inc;
            OP_JUMP:   addr_d = bus.target;
            OP_CALL: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  addr_d  = bus.target;
                  depth_d = depth_q + DEPTH_ONE;
               end
            end
            OP_RET: begin
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  addr_d  = stack_q[pop_idx];
                  depth_d = depth_q - DEPTH_ONE;
               end
            end
            // INC and the reserved encodings all advance by one
            default:   addr_d = addr_inc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack entries need no reset: only slots below depth are ever read.
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_q[push_idx] <= addr_inc;
      end
   end

   assign bus.addr        = addr_q;
   assign bus.depth       = depth_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.err_ovf     = ovf_q;
   assign bus.err_unf     = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack.sv
// ============================================================================
// Module   : tb_pc_stack
// Brief    : Directed self-checking bench for pc_stack (AddrSz=6, Depth=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_stack;
   localparam logic [2:0] INC  = 3'b000;
   localparam logic [2:0] BRA  = 3'b001;
   localparam logic [2:0] JMP  = 3'b010;
   localparam logic [2:0] CALL = 3'b011;
   localparam logic [2:0] RET  = 3'b100;
   localparam logic [2:0] RSV  = 3'b101;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   pc_stack_if #(.AddrSz(6), .Depth(4)) bus ();

   pc_stack #(.AddrSz(6), .Depth(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [5:0] a, input logic [2:0] d,
                         input logic ovf, input logic unf);
      chk({tag, ".addr"}, 32'(bus.addr), 32'(a));
      chk({tag, ".depth"}, 32'(bus.depth), 32'(d));
      chk({tag, ".full"}, 32'(bus.stack_full), 32'(d == 3'd4));
      chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(d == 3'd0));
      chk({tag, ".ovf"}, 32'(bus.err_ovf), 32'(ovf));
      chk({tag, ".unf"}, 32'(bus.err_unf), 32'(unf));
   endtask

   task automatic step(input logic [2:0] op, input logic cond, input logic [5:0] off,
                       input logic [5:0] tgt, input logic stl, input logic rst);
      @(negedge clk);
      bus.op     = op;
      bus.cond   = cond;
      bus.offset = off;
      bus.target = tgt;
      bus.stall  = stl;
      reset      = rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.stall  = 1'b0;
      bus.op     = INC;
      bus.cond   = 1'b0;
      bus.offset = '0;
      bus.target = '0;
      @(posedge clk);
      #1;
      chk_st("reset", 6'd0, 3'd0, 1'b0, 1'b0);

      step(INC, 0, 0, 0, 0, 0); chk_st("inc1", 6'd1, 3'd0, 0, 0);
      step(INC, 0, 0, 0, 0, 0); chk_st("inc2", 6'd2, 3'd0, 0, 0);
      step(INC, 0, 0, 0, 0, 0); chk_st("inc3", 6'd3, 3'd0, 0, 0);

      step(JMP, 1, 0, 6'd62, 0, 0); chk("jmp62", 32'(bus.addr), 32'd62);
      step(INC, 0, 0, 0, 0, 0);     chk("wrap63", 32'(bus.addr), 32'd63);
      step(INC, 0, 0, 0, 0, 0);     chk("wrap0", 32'(bus.addr), 32'd0);
      step(INC, 0, 0, 0, 0, 0);     chk("wrap1", 32'(bus.addr), 32'd1);
      step(BRA, 1, 6'h3D, 0, 0, 0); chk("bra_taken", 32'(bus.addr), 32'd62);
      step(BRA, 0, 6'h3D, 0, 0, 0); chk("bra_not", 32'(bus.addr), 32'd63);

      step(JMP, 0, 0, 6'd5, 0, 0);    chk("jmp5", 32'(bus.addr), 32'd5);
      step(CALL, 0, 0, 6'd20, 0, 0);  chk_st("call20", 6'd20, 3'd1, 0, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret6", 6'd6, 3'd0, 0, 0);
      step(JMP, 0, 0, 6'd63, 0, 0);   chk("jmp63", 32'(bus.addr), 32'd63);
      step(CALL, 0, 0, 6'd7, 0, 0);   chk_st("call_wrap", 6'd7, 3'd1, 0, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret_wrap", 6'd0, 3'd0, 0, 0);

      step(JMP, 0, 0, 6'd1, 0, 0);    chk("jmp1", 32'(bus.addr), 32'd1);
      step(CALL, 0, 0, 6'd10, 0, 0);  chk_st("call10", 6'd10, 3'd1, 0, 0);
      step(CALL, 0, 0, 6'd20, 0, 0);  chk_st("call20b", 6'd20, 3'd2, 0, 0);
      step(CALL, 0, 0, 6'd30, 0, 0);  chk_st("call30", 6'd30, 3'd3, 0, 0);
      step(CALL, 0, 0, 6'd40, 0, 0);  chk_st("call40", 6'd40, 3'd4, 0, 0);
      step(CALL, 0, 0, 6'd50, 0, 0);  chk_st("ovf", 6'd40, 3'd4, 1, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret31", 6'd31, 3'd3, 1, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret21", 6'd21, 3'd2, 1, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret11", 6'd11, 3'd1, 1, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret2", 6'd2, 3'd0, 1, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("unf", 6'd2, 3'd0, 1, 1);
      step(RSV, 1, 6'h3D, 6'd9, 0, 0); chk_st("reserved", 6'd3, 3'd0, 1, 1);

      step(JMP, 0, 0, 6'd40, 1, 0);   chk_st("stall_jmp", 6'd3, 3'd0, 1, 1);
      step(CALL, 0, 0, 6'd10, 0, 0);  chk_st("pre_call1", 6'd10, 3'd1, 1, 1);
      step(CALL, 0, 0, 6'd20, 1, 0);  chk_st("stall_call", 6'd10, 3'd1, 1, 1);
      step(CALL, 0, 0, 6'd20, 0, 0);  chk_st("pre_call2", 6'd20, 3'd2, 1, 1);
      step(CALL, 0, 0, 6'd30, 1, 1);  chk_st("rst_stall", 6'd0, 3'd0, 0, 0);
      step(INC, 0, 0, 0, 0, 0);       chk_st("first_op", 6'd1, 3'd0, 0, 0);
      step(RET, 0, 0, 0, 0, 0);       chk_st("ret_after_rst", 6'd1, 3'd0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
